// File: rtl/branch_outcome_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// reset state and default geometry.
package branch_outcome_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET      = WNT;
    localparam int         DEF_INDEX_BITS = 6;
    localparam int         DEF_HIST_BITS  = 6;

    // Direction encoded by a counter: the MSB separates the taken half.
    function automatic logic ctr_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_outcome_predictor_sat_counter2.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_outcome_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_outcome_predictor.sv
// gshare direction predictor: registered prediction to fetch, training and
// mispredict detection from EX, saturating performance statistics.
module branch_outcome_predictor
    import branch_outcome_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int HIST_BITS  = DEF_HIST_BITS,
    parameter int STAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_req,
    input  logic [31:0]           pred_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  resolve_valid,
    input  logic [INDEX_BITS-1:0] resolve_index,
    input  logic                  resolve_taken,
    input  logic                  resolve_pred,
    input  logic                  flush,
    output logic                  mispredict,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_nxt;
    logic [1:0]            pred_ctr;
    logic                  is_mispredict;

    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic                  mispredict_q, mispredict_d;
    logic [STAT_BITS-1:0]  stat_br_q, stat_br_d;
    logic [STAT_BITS-1:0]  stat_mp_q, stat_mp_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

    // Global history; with no history bits the index degenerates to bimodal.
    generate
        if (HIST_BITS == 0) begin : g_no_ghr
            assign ghr_ext = '0;
        end else begin : g_ghr
            logic [HIST_BITS-1:0] ghr_q;
            logic [HIST_BITS-1:0] ghr_d;

            if (HIST_BITS == 1) begin : g_one
                assign ghr_d = resolve_valid ? resolve_taken : ghr_q;
            end else begin : g_shift
                assign ghr_d = resolve_valid ? {ghr_q[HIST_BITS-2:0], resolve_taken} : ghr_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_q <= '0;
                end else begin
                    ghr_q <= ghr_d;
                end
            end

            assign ghr_ext = INDEX_BITS'(ghr_q);
        end
    endgenerate

    assign pred_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_ext;
    assign upd_cur  = table_q[resolve_index];

    sat_counter2 u_sat (
        .cur   (upd_cur),
        .taken (resolve_taken),
        .nxt   (upd_nxt)
    );

    // Same-edge collision: the prediction sees the counter after training.
    always_comb begin
        pred_ctr = table_q[pred_idx];
        if (resolve_valid && (resolve_index == pred_idx)) begin
            pred_ctr = upd_nxt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    table_q[gi] <= CTR_RESET;
                end else if (resolve_valid && (resolve_index == INDEX_BITS'(gi))) begin
                    table_q[gi] <= upd_nxt;
                end
            end
        end
    endgenerate

    assign is_mispredict = resolve_valid && (resolve_taken != resolve_pred);

    always_comb begin
        pred_valid_d = pred_req && !flush;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (pred_req && !flush) begin
            pred_taken_d = ctr_taken(pred_ctr);
            pred_index_d = pred_idx;
        end
    end

    always_comb begin
        mispredict_d = is_mispredict;
        stat_br_d    = stat_br_q;
        stat_mp_d    = stat_mp_q;
        if (resolve_valid && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + STAT_BITS'(1);
        end
        if (is_mispredict && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            mispredict_q <= 1'b0;
            stat_br_q    <= '0;
            stat_mp_q    <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
            mispredict_q <= mispredict_d;
            stat_br_q    <= stat_br_d;
            stat_mp_q    <= stat_mp_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_index       = pred_index_q;
    assign mispredict       = mispredict_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Directed bench: a bimodal instance with 4-bit stats and a gshare instance
// with 6 history bits, sharing clock and reset.
module tb_branch_outcome_predictor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Bimodal instance (HIST_BITS = 0, STAT_BITS = 4)
    logic        b_req, b_rv, b_rt, b_rp, b_flush;
    logic [31:0] b_pc;
    logic [5:0]  b_ridx;
    logic        b_pv, b_pt, b_mp;
    logic [5:0]  b_pi;
    logic [3:0]  b_sb, b_sm;

    // gshare instance (HIST_BITS = 6, STAT_BITS = 32)
    logic        g_req, g_rv, g_rt, g_rp, g_flush;
    logic [31:0] g_pc;
    logic [5:0]  g_ridx;
    logic        g_pv, g_pt, g_mp;
    logic [5:0]  g_pi;
    logic [31:0] g_sb, g_sm;

    int checks = 0;
    int errors = 0;

    branch_outcome_predictor #(.INDEX_BITS(6), .HIST_BITS(0), .STAT_BITS(4)) u_bim (
        .clk(clk), .rst_n(rst_n),
        .pred_req(b_req), .pred_pc(b_pc),
        .pred_valid(b_pv), .pred_taken(b_pt), .pred_index(b_pi),
        .resolve_valid(b_rv), .resolve_index(b_ridx),
        .resolve_taken(b_rt), .resolve_pred(b_rp),
        .flush(b_flush), .mispredict(b_mp),
        .stat_branches(b_sb), .stat_mispredicts(b_sm)
    );

    branch_outcome_predictor #(.INDEX_BITS(6), .HIST_BITS(6), .STAT_BITS(32)) u_gsh (
        .clk(clk), .rst_n(rst_n),
        .pred_req(g_req), .pred_pc(g_pc),
        .pred_valid(g_pv), .pred_taken(g_pt), .pred_index(g_pi),
        .resolve_valid(g_rv), .resolve_index(g_ridx),
        .resolve_taken(g_rt), .resolve_pred(g_rp),
        .flush(g_flush), .mispredict(g_mp),
        .stat_branches(g_sb), .stat_mispredicts(g_sm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b_idle();
        b_req = 0; b_rv = 0; b_flush = 0;
    endtask

    task automatic b_resolve(input logic [5:0] idx, input logic t, input logic p);
        b_rv = 1; b_ridx = idx; b_rt = t; b_rp = p;
    endtask

    task automatic b_predict(input logic [31:0] pc);
        b_req = 1; b_pc = pc;
    endtask

    initial begin
        rst_n = 0;
        b_req = 0; b_pc = 0; b_rv = 0; b_ridx = 0; b_rt = 0; b_rp = 0; b_flush = 0;
        g_req = 0; g_pc = 0; g_rv = 0; g_ridx = 0; g_rt = 0; g_rp = 0; g_flush = 0;
        #2;
        check("rst_pv", {31'd0, b_pv}, 32'd0);
        check("rst_mp", {31'd0, b_mp}, 32'd0);
        step();
        rst_n = 1;

        // First prediction after reset: PC 0x40 -> index 0x10, weakly not-taken
        b_predict(32'h40); step(); b_idle();
        check("p0_valid", {31'd0, b_pv}, 32'd1);
        check("p0_taken", {31'd0, b_pt}, 32'd0);
        check("p0_index", {26'd0, b_pi}, 32'h10);
        check("p0_sb", {28'd0, b_sb}, 32'd0);
        check("p0_sm", {28'd0, b_sm}, 32'd0);
        step();
        check("idle_valid", {31'd0, b_pv}, 32'd0);
        check("hold_index", {26'd0, b_pi}, 32'h10);

        // Four mispredicted taken resolves, each followed by an idle cycle
        for (int i = 0; i < 4; i++) begin
            b_resolve(6'h10, 1, 0); step(); b_idle();
            check("mp_pulse", {31'd0, b_mp}, 32'd1);
            step();
            check("mp_clear", {31'd0, b_mp}, 32'd0);
        end
        check("sb4", {28'd0, b_sb}, 32'd4);
        check("sm4", {28'd0, b_sm}, 32'd4);
        b_predict(32'h40); step(); b_idle();
        check("st_taken", {31'd0, b_pt}, 32'd1);

        // Fifth taken, correctly predicted: stays ST, no mispredict
        b_resolve(6'h10, 1, 1); step(); b_idle();
        check("no_mp", {31'd0, b_mp}, 32'd0);
        b_resolve(6'h10, 0, 1); step(); b_idle();
        check("mp_nt1", {31'd0, b_mp}, 32'd1);
        b_predict(32'h40); step(); b_idle();
        check("wt_taken", {31'd0, b_pt}, 32'd1);
        b_resolve(6'h10, 0, 1); step(); b_idle();
        b_predict(32'h40); step(); b_idle();
        check("wnt_taken", {31'd0, b_pt}, 32'd0);
        check("sb7", {28'd0, b_sb}, 32'd7);
        check("sm6", {28'd0, b_sm}, 32'd6);

        // Same-edge bypass: WNT entry trained taken while being predicted
        b_resolve(6'h10, 1, 0); b_predict(32'h40); step(); b_idle();
        check("byp_valid", {31'd0, b_pv}, 32'd1);
        check("byp_taken", {31'd0, b_pt}, 32'd1);

        // Flush kills the prediction and leaves the table alone
        b_predict(32'h40); b_flush = 1; step(); b_idle();
        check("flush_valid", {31'd0, b_pv}, 32'd0);
        b_predict(32'h40); step(); b_idle();
        check("post_flush", {31'd0, b_pt}, 32'd1);
        b_predict(32'h44); step(); b_idle();
        check("other_index", {26'd0, b_pi}, 32'h11);
        check("other_taken", {31'd0, b_pt}, 32'd0);

        // Drive branch count past 4-bit saturation: 8 so far, 9 more
        for (int i = 0; i < 9; i++) begin
            b_resolve(6'h20, 0, 0); step();
        end
        b_idle();
        check("sb_sat", {28'd0, b_sb}, 32'hF);
        check("sm_hold", {28'd0, b_sm}, 32'd7);

        // gshare history: outcomes 1,0,1,1,0,1 at index 0
        for (int i = 0; i < 6; i++) begin
            g_rv = 1; g_ridx = 6'h00; g_rp = 0;
            g_rt = (i == 1 || i == 4) ? 1'b0 : 1'b1;
            step();
        end
        g_rv = 0;
        g_req = 1; g_pc = 32'h0; step(); g_req = 0;
        check("ghr_index", {26'd0, g_pi}, 32'h2D);
        check("ghr_taken", {31'd0, g_pt}, 32'd0);
        check("g_sb", g_sb, 32'd6);
        check("g_sm", g_sm, 32'd4);
        // PC 0xB4 -> 0x2D ^ 0x2D = index 0, trained to ST by the sequence
        g_req = 1; g_pc = 32'hB4; step(); g_req = 0;
        check("ghr_idx0", {26'd0, g_pi}, 32'h00);
        check("ghr_taken0", {31'd0, g_pt}, 32'd1);

        // Asynchronous reset while a prediction is valid
        b_predict(32'h40); step(); b_idle();
        check("pre_rst_pv", {31'd0, b_pv}, 32'd1);
        #3;
        rst_n = 0;
        #1;
        check("arst_pv", {31'd0, b_pv}, 32'd0);
        check("arst_pt", {31'd0, b_pt}, 32'd0);
        check("arst_pi", {26'd0, b_pi}, 32'd0);
        check("arst_sb", {28'd0, b_sb}, 32'd0);
        check("arst_sm", {28'd0, b_sm}, 32'd0);
        check("arst_gsb", g_sb, 32'd0);
        step();
        rst_n = 1;
        b_predict(32'h40); step(); b_idle();
        check("rst_table", {31'd0, b_pt}, 32'd0);
        check("rst_valid", {31'd0, b_pv}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
